// File: rtl/summ_complex_arbiter_pkg.sv
// Shared constants and packed-bus helpers for the complex-adder arbiter slice.
// Requester k of a packed bus occupies bits [k*W +: W].
package summ_complex_arbiter_pkg;

    localparam int unsigned DataFftSize = 16;
    localparam int unsigned NReqDefault = 4;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/summ_complex_arbiter_add.sv
// Registered complex adder: sum updates only when enabled, otherwise holds.
// No reset; contents are meaningless until the first enabled cycle.
module summ_complex_arbiter_add #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [Width-1:0] a_re_i,
    input  logic [Width-1:0] a_im_i,
    input  logic [Width-1:0] b_re_i,
    input  logic [Width-1:0] b_im_i,
    output logic [Width-1:0] sum_re_o,
    output logic [Width-1:0] sum_im_o
);

    logic [Width-1:0] sum_re_q;
    logic [Width-1:0] sum_im_q;

    // Modulo 2^Width: carry out is dropped.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            sum_re_q <= a_re_i + b_re_i;
            sum_im_q <= a_im_i + b_im_i;
        end
    end

    assign sum_re_o = sum_re_q;
    assign sum_im_o = sum_im_q;

endmodule

// File: rtl/summ_complex_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NReq. Grants nothing unless accept_i is high.
module summ_complex_arbiter_rr #(
    parameter  int unsigned NReq = 4,
    localparam int unsigned IdW  = $clog2(NReq)
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    input  logic            accept_i,
    output logic [NReq-1:0] grant_o,
    output logic [IdW-1:0]  grant_id_o
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned off = 0; off < NReq; off++) begin
            idx = (32'(ptr_i) + off) % NReq;
            if (accept_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/summ_complex_arbiter.sv
// Shares one registered complex adder between N_REQ valid/ready requesters,
// round-robin, returning each sum tagged with its requester id.
module summ_complex_arbiter
    import summ_complex_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_FFT_SIZE = DataFftSize,
    parameter  int unsigned N_REQ         = NReqDefault,
    localparam int unsigned ID_W          = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_FFT_SIZE-1:0] req_in0_i,
    input  logic [N_REQ*DATA_FFT_SIZE-1:0] req_in0_q,
    input  logic [N_REQ*DATA_FFT_SIZE-1:0] req_in1_i,
    input  logic [N_REQ*DATA_FFT_SIZE-1:0] req_in1_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_FFT_SIZE-1:0]   out_i,
    output logic [DATA_FFT_SIZE-1:0]   out_q,
    output logic [ID_W-1:0]            out_id
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             accept;
    logic             add_en;
    int unsigned      lane;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q;

    // Slot is free, or its current occupant leaves this cycle.
    assign accept = !out_valid_q || out_ready;

    // Gating with rst_n keeps req_ready low and the adder idle during reset.
    summ_complex_arbiter_rr #(
        .NReq (N_REQ)
    ) u_rr (
        .req_i      (req_valid),
        .ptr_i      (ptr_q),
        .accept_i   (accept && rst_n),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready = grant;
    assign add_en    = |grant;
    assign lane      = lane_lsb(32'(grant_id), DATA_FFT_SIZE);

    summ_complex_arbiter_add #(
        .Width (DATA_FFT_SIZE)
    ) u_add (
        .clk_i    (clk),
        .en_i     (add_en),
        .a_re_i   (req_in0_i[lane +: DATA_FFT_SIZE]),
        .a_im_i   (req_in0_q[lane +: DATA_FFT_SIZE]),
        .b_re_i   (req_in1_i[lane +: DATA_FFT_SIZE]),
        .b_im_i   (req_in1_q[lane +: DATA_FFT_SIZE]),
        .sum_re_o (out_i),
        .sum_im_o (out_q)
    );

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        if (add_en) begin
            ptr_d       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            if (add_en) begin
                out_id_q <= grant_id;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_summ_complex_arbiter.sv
// Bench for summ_complex_arbiter: arithmetic and grant-sequence tables plus a
// reference arbitration model feeding a result scoreboard.
module tb_summ_complex_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in0_i, req_in0_q, req_in1_i, req_in1_q;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_i, out_q;
    logic [1:0]     out_id;

    summ_complex_arbiter #(
        .DATA_FFT_SIZE (W),
        .N_REQ         (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0_i (req_in0_i),
        .req_in0_q (req_in0_q),
        .req_in1_i (req_in1_i),
        .req_in1_q (req_in1_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] i;
        logic [W-1:0] q;
    } sb_t;
    sb_t sbq[$];

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int p);
        logic [N-1:0] one;
        one = 1;
        for (int o = 0; o < N; o++) begin
            if (v[(p + o) % N]) return one << ((p + o) % N);
        end
        return '0;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
    logic         mon_en = 1'b0;
    logic         m_valid = 1'b0;
    int           m_ptr = 0;
    always @(negedge clk) begin
        logic [N-1:0] g;
        sb_t          e;
        if (mon_en) begin
            g = (rst_n && (!m_valid || out_ready)) ? model_grant(req_valid, m_ptr) : '0;
            check("model_ready", req_ready, g);
            check("model_out_valid", out_valid, m_valid);
            if (m_valid) begin
                if (sbq.size() == 0) begin
                    check("sb_nonempty", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq[0];
                    check("sb_out_i", out_i, e.i);
                    check("sb_out_q", out_q, e.q);
                    check("sb_out_id", out_id, e.id);
                    if (out_ready && rst_n) void'(sbq.pop_front());
                end
            end
            if (!rst_n) begin
                m_valid = 1'b0;
                m_ptr   = 0;
                sbq.delete();
            end else if (g != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g[k]) begin
                        e.id = 2'(k);
                        e.i  = req_in0_i[k*W +: W] + req_in1_i[k*W +: W];
                        e.q  = req_in0_q[k*W +: W] + req_in1_q[k*W +: W];
                        sbq.push_back(e);
                        m_ptr = (k + 1) % N;
                    end
                end
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    typedef struct {
        int           k;
        logic [W-1:0] a_i, a_q, b_i, b_q, s_i, s_q;
    } arith_t;

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] exp;
    } rr_t;

    arith_t ar_tab[4];
    rr_t    rr_tab[22];

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        ar_tab[0] = '{0, 16'h0003, 16'h0005, 16'h0004, 16'hFFFE, 16'h0007, 16'h0003};
        ar_tab[1] = '{1, 16'hFFFF, 16'h0000, 16'h0002, 16'h0000, 16'h0001, 16'h0000};
        ar_tab[2] = '{2, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'h8000};
        ar_tab[3] = '{3, 16'h1234, 16'hABCD, 16'h1111, 16'h1111, 16'h2345, 16'hBCDE};

        // Starts with ptr=0 after the arithmetic table (last requester was 3).
        rr_tab[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001};
        rr_tab[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010};
        rr_tab[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100};
        rr_tab[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000};
        rr_tab[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001};
        rr_tab[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010};
        rr_tab[6]  = '{1'b1, 4'b0011, 1'b1, 4'b0001};  // ptr=2 skips to 0
        rr_tab[7]  = '{1'b1, 4'b0011, 1'b1, 4'b0010};
        rr_tab[8]  = '{1'b1, 4'b0011, 1'b0, 4'b0000};  // stall x3
        rr_tab[9]  = '{1'b1, 4'b0011, 1'b0, 4'b0000};
        rr_tab[10] = '{1'b1, 4'b0011, 1'b0, 4'b0000};
        rr_tab[11] = '{1'b1, 4'b0011, 1'b1, 4'b0001};  // drain and grant same cycle
        rr_tab[12] = '{1'b1, 4'b1100, 1'b1, 4'b0100};
        rr_tab[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000};
        rr_tab[14] = '{1'b1, 4'b0000, 1'b0, 4'b0000};
        rr_tab[15] = '{1'b1, 4'b1000, 1'b0, 4'b1000};  // empty slot accepts without out_ready
        rr_tab[16] = '{1'b1, 4'b1000, 1'b0, 4'b0000};
        rr_tab[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000};  // reset with result pending
        rr_tab[18] = '{1'b1, 4'b1111, 1'b1, 4'b0001};
        rr_tab[19] = '{1'b1, 4'b1111, 1'b1, 4'b0010};
        rr_tab[20] = '{1'b1, 4'b0000, 1'b1, 4'b0000};
        rr_tab[21] = '{1'b1, 4'b0000, 1'b1, 4'b0000};

        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        req_in0_i = '0; req_in0_q = '0; req_in1_i = '0; req_in1_q = '0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_id", out_id, 2'd0);
        check("rst_req_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            req_in0_i[ar_tab[t].k*W +: W] = ar_tab[t].a_i;
            req_in0_q[ar_tab[t].k*W +: W] = ar_tab[t].a_q;
            req_in1_i[ar_tab[t].k*W +: W] = ar_tab[t].b_i;
            req_in1_q[ar_tab[t].k*W +: W] = ar_tab[t].b_q;
            req_valid = 4'b0001 << ar_tab[t].k;
            @(negedge clk);
            check("ar_ready", req_ready, 4'b0001 << ar_tab[t].k);
            @(posedge clk);
            #1 req_valid = '0;
            @(negedge clk);
            check("ar_out_valid", out_valid, 1'b1);
            check("ar_out_i", out_i, ar_tab[t].s_i);
            check("ar_out_q", out_q, ar_tab[t].s_q);
            check("ar_out_id", out_id, 32'(ar_tab[t].k));
        end

        for (int t = 0; t < 22; t++) begin
            @(posedge clk);
            #1;
            rst_n     = rr_tab[t].rst;
            req_valid = rr_tab[t].valid;
            out_ready = rr_tab[t].ordy;
            for (int k = 0; k < N; k++) begin
                req_in0_i[k*W +: W] = 16'($urandom);
                req_in0_q[k*W +: W] = 16'($urandom);
                req_in1_i[k*W +: W] = 16'($urandom);
                req_in1_q[k*W +: W] = 16'($urandom);
            end
            @(negedge clk);
            check("rr_grant", req_ready, rr_tab[t].exp);
        end

        @(posedge clk);
        #1 req_valid = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("idle_out_valid", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
